move_input: RTL
===============

# move_input

Front-end conditioner for the nine tic-tac-toe cell buttons, sitting directly upstream of `tic_tac_toe`. It synchronises and debounces the raw push-buttons and enforces exactly one cell per press. Each accepted press becomes a single-cycle pulse on the matching `*_button` input of the game core. Presses are rejected while the game is over or when more than one cell is held.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed to accept a press or a release (minimum 2).
- `CNT_W`, default 5: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `raw_btn` input 9: asynchronous button levels, 1 = pressed; bit 0 = cell a … bit 8 = cell i.
- `game_over` input 1: level, driven from `p1_win | p2_win | grid_full` of the core.
- `move_pulse` output 9: one-hot move strobe, bit n drives the nth `*_button` of the core.
- `reject_pulse` output 1: one-cycle strobe for a debounced press that was refused.
- `busy` output 1: high in any state other than IDLE.
- `move_count` output 4: accepted moves since reset. Present only with `MOVE_COUNT_EN`.

## Operation
- **Synchroniser:** `raw_btn` passes through two flops, giving `sync_btn`. All decisions use `sync_btn` only.
- **FSM states:** IDLE, DEBOUNCE, ACCEPT, REJECT, RELEASE.
- **IDLE**
  - If `sync_btn != 0`: capture `cand <= sync_btn`, `cnt <= 0`, go to DEBOUNCE.
- **DEBOUNCE**
  - If `sync_btn != cand`: go to IDLE, discarding the press. A bounce restarts qualification.
  - Else if `cnt == DEBOUNCE_CYCLES-1`:
    - go to ACCEPT if `cand` is one-hot and `game_over == 0`;
    - otherwise go to REJECT.
  - Else `cnt <= cnt + 1`.
- **ACCEPT:** `move_pulse = cand` for this one cycle. Unconditionally go to RELEASE with `cnt <= 0`.
- **REJECT:** `reject_pulse = 1` for this one cycle. Go to RELEASE with `cnt <= 0`.
- **RELEASE**
  - If `sync_btn != 0`: `cnt <= 0`. Holding, or adding a second button, never produces a new move.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: go to IDLE.
  - Else `cnt <= cnt + 1`.
- **Game-over sampling:** `game_over` is sampled only on the DEBOUNCE→ACCEPT/REJECT decision edge. If it rises while in ACCEPT, the already-issued pulse stands.
- **Output decode:** `move_pulse` and `reject_pulse` are decoded from registered state and `cand` only, with no input-to-output combinational path. They are never high simultaneously.
- **Illegal cells:** a press on an already-occupied cell is passed through. The core ignores it; this block has no knowledge of grid contents.

## Timing
- **Reset (synchronous, active-high):** on any edge with `reset = 1`:
  - state = IDLE;
  - `cand`, `cnt` and both synchroniser stages = 0;
  - `move_pulse` = 0, `reject_pulse` = 0, `busy` = 0, `move_count` = 0.
- **Reset mid-operation:** a reset during DEBOUNCE, ACCEPT or RELEASE aborts without emitting any pulse.
- **Latency:** let edge k be the first edge that samples a clean press.
  - DEBOUNCE is entered at edge k+2.
  - The pulse cycle (ACCEPT or REJECT) begins at edge k+DEBOUNCE_CYCLES+2, i.e. edge 18 for the default.
  - The pulse lasts exactly one cycle.
- **Minimum press-to-press spacing** is the press latency, plus 1, plus DEBOUNCE_CYCLES of clean release.
- **Bounce:** a glitch of N cycles inside DEBOUNCE returns the FSM to IDLE. Re-qualification starts from zero.
- **Counter:** `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps.

## Configuration
- **`MOVE_COUNT_EN` defined:**
  - `move_count` port exists;
  - it increments on each ACCEPT cycle and saturates at 9;
  - it clears only on `reset`.
- **Not defined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Clean press:** reset, then `raw_btn = 9'h010` held 30 cycles from edge 0.
  - `move_pulse = 9'h010` only during the cycle starting at edge 18.
  - `busy` is high from edge 2 until 16 cycles after release is seen.
- **Bounce:** `raw_btn = 9'h001` for 5 cycles, 0 for 2 cycles, then held.
  - No pulse from the first segment.
  - A single `move_pulse = 9'h001` 18 edges after the final rise.
- **Multi-press:** `raw_btn = 9'h003` held.
  - `reject_pulse` for 1 cycle at edge 18.
  - `move_pulse` stays 0; `move_count` stays 0.
- **Game over:** `game_over = 1`, press cell i (`9'h100`).
  - `reject_pulse` only.
  - Repeat with `game_over = 0`: `move_pulse = 9'h100`.
- **Held button plus second press:** hold `9'h002` for 100 cycles, adding `9'h004` at cycle 40.
  - Exactly one `move_pulse = 9'h002` in total; no further strobes.
- **Reset mid-debounce, and count saturation:**
  - Assert `reset` at edge 10 of a press: no pulse, all outputs 0.
  - With `MOVE_COUNT_EN`, 11 clean presses leave `move_count = 9`.

Source files
------------

// File: rtl/move_input_if.sv
// Button-conditioner bus between the raw cell buttons / game core and move_input.
// MOVE_COUNT_EN adds the move_count signal to the bundle.
interface move_input_if;
    logic [8:0] raw_btn;
    logic       game_over;
    logic [8:0] move_pulse;
    logic       reject_pulse;
    logic       busy;
`ifdef MOVE_COUNT_EN
    logic [3:0] move_count;

    modport master (
        output raw_btn, game_over,
        input  move_pulse, reject_pulse, busy, move_count
    );
    modport slave (
        input  raw_btn, game_over,
        output move_pulse, reject_pulse, busy, move_count
    );
`else
    modport master (
        output raw_btn, game_over,
        input  move_pulse, reject_pulse, busy
    );
    modport slave (
        input  raw_btn, game_over,
        output move_pulse, reject_pulse, busy
    );
`endif
endinterface

// File: rtl/move_input.sv
// Synchronise, debounce and one-cell-per-press filter for the tic-tac-toe buttons.
// Optional feature: define MOVE_COUNT_EN to add the saturating move_count output.
module move_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic         clk,
    input  logic         reset,
    move_input_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        ACCEPT   = 3'd2,
        REJECT   = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [8:0]       sync1_r;
    logic [8:0]       sync2_r;
    logic [8:0]       cand_r;
    logic [8:0]       cand_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [8:0]       move_pulse_r;
    logic             reject_pulse_r;
    logic             busy_r;

    function automatic logic is_one_hot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 9'd0;
            sync2_r <= 9'd0;
        end else begin
            sync1_r <= bus.raw_btn;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, candidate and qualification counter logic
    always_comb begin
        state_s = state_r;
        cand_s  = cand_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (sync2_r != 9'd0) begin
                    cand_s  = sync2_r;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = DEBOUNCE;
                end else begin
                    state_s = IDLE;
                end
            end
            DEBOUNCE: begin
                // game_over only matters on this decision edge
                if (sync2_r != cand_r) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    if (is_one_hot(cand_r) && !bus.game_over) begin
                        state_s = ACCEPT;
                    end else begin
                        state_s = REJECT;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ACCEPT: begin
                state_s = RELEASE;
                cnt_s   = {CNT_W{1'b0}};
            end
            REJECT: begin
                state_s = RELEASE;
                cnt_s   = {CNT_W{1'b0}};
            end
            RELEASE: begin
                // Any held button restarts the release window, so no re-trigger
                if (sync2_r != 9'd0) begin
                    cnt_s = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cand_s  = 9'd0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            cand_r         <= 9'd0;
            cnt_r          <= {CNT_W{1'b0}};
            move_pulse_r   <= 9'd0;
            reject_pulse_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            cand_r         <= cand_s;
            cnt_r          <= cnt_s;
            move_pulse_r   <= (state_s == ACCEPT) ? cand_r : 9'd0;
            reject_pulse_r <= (state_s == REJECT);
            busy_r         <= (state_s != IDLE);
        end
    end

    assign bus.move_pulse   = move_pulse_r;
    assign bus.reject_pulse = reject_pulse_r;
    assign bus.busy         = busy_r;

`ifdef MOVE_COUNT_EN
    logic [3:0] move_count_r;

    // Accepted-move counter, saturating at a full grid of nine
    always_ff @(posedge clk) begin
        if (reset) begin
            move_count_r <= 4'd0;
        end else if ((state_r == ACCEPT) && (move_count_r != 4'd9)) begin
            move_count_r <= move_count_r + 4'd1;
        end else begin
            move_count_r <= move_count_r;
        end
    end

    assign bus.move_count = move_count_r;
`endif

endmodule
